// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-access stage. Accepts an effective address, store data
//               and destination register from execute, performs a single
//               data-memory transaction over a req/ack bus and returns aligned,
//               sign/zero-extended load data for writeback. Misaligned,
//               illegal-size and timed-out accesses report an exception.
// Ports       : clk, rst (async, active-high)
//               i_req_*  : request from execute (valid/ready handshake)
//               o_mem_*  : memory request bus, i_mem_rdata/i_mem_ack response
//               o_done_valid, o_wb_* : one-cycle completion with writeback
//               o_exc_*  : exception report qualified by o_done_valid
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 64,    // BUSY cycles without ack before fault, 1..65535
    parameter bit TIMEOUT_EN     = 1'b1   // 0: wait for ack forever
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [3:0]  i_req_fn,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [4:0]  i_req_rd,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_wstrb,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_done_valid,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_exc_valid,
    output logic [3:0]  o_exc_cause,
    output logic [31:0] o_exc_addr
);

    localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_store;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [4:0]  r_rd;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [15:0] r_cnt;
    logic        r_exc;
    logic [3:0]  r_cause;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misal;
    logic        w_expire;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_load;
    logic        w_busy;
    logic        w_done;
    logic        w_ok_load;

    assign w_accept  = i_req_valid && (r_state == S_IDLE);
    assign w_illegal = (i_req_fn[1:0] == 2'b11);
    assign w_misal   = ((i_req_fn[1:0] == 2'b01) && i_req_addr[0]) ||
                       ((i_req_fn[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
    // The last counted cycle expires only if no ack arrives in it: ack wins.
    assign w_expire  = TIMEOUT_EN && !i_mem_ack && (r_cnt == C_CNT_LAST);

    // Store lane steering computed from the incoming request.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = i_req_wdata;
        case (i_req_fn[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << i_req_addr[1:0];
                w_wdata = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << i_req_addr[1:0];
                w_wdata = {2{i_req_wdata[15:0]}};
            end
            default: w_wstrb = 4'b1111;
        endcase
        if (!i_req_fn[3]) begin
            w_wstrb = 4'b0000;
        end
    end

    // Load extraction: shift the addressed lane down to bit 0, then extend.
    assign w_lane = i_mem_rdata >> {r_addr[1:0], 3'b000};
    always_comb begin
        w_load = i_mem_rdata;
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_lane[7]}},  w_lane[7:0]};
            2'b01:   w_load = {{16{~r_unsigned & w_lane[15]}}, w_lane[15:0]};
            default: w_load = i_mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_illegal || w_misal) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (i_mem_ack || w_expire) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, timeout counter and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_store    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= 32'd0;
            r_rd       <= 5'd0;
            r_wstrb    <= 4'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_cnt      <= 16'd0;
            r_exc      <= 1'b0;
            r_cause    <= 4'd0;
        end else begin
            if (w_accept) begin
                r_store    <= i_req_fn[3];
                r_unsigned <= i_req_fn[2];
                r_size     <= i_req_fn[1:0];
                r_addr     <= i_req_addr;
                r_rd       <= i_req_rd;
                r_wstrb    <= w_wstrb;
                r_wdata    <= w_wdata;
                r_rdata    <= 32'd0;
                r_cnt      <= 16'd0;
                r_exc      <= w_illegal || w_misal;
                r_cause    <= w_illegal ? 4'd2 : (i_req_fn[3] ? 4'd6 : 4'd4);
            end else if (r_state == S_BUSY) begin
                if (i_mem_ack) begin
                    r_rdata <= w_load;
                end else if (w_expire) begin
                    r_exc   <= 1'b1;
                    r_cause <= r_store ? 4'd7 : 4'd5;
                end else if (TIMEOUT_EN) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

    assign w_busy    = (r_state == S_BUSY);
    assign w_done    = (r_state == S_DONE);
    assign w_ok_load = w_done && !r_exc && !r_store;

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_mem_req    = w_busy;
    assign o_mem_we     = w_busy && r_store;
    assign o_mem_addr   = w_busy ? {r_addr[31:2], 2'b00} : 32'd0;
    assign o_mem_wstrb  = w_busy ? r_wstrb : 4'd0;
    assign o_mem_wdata  = w_busy ? r_wdata : 32'd0;

    assign o_done_valid = w_done;
    assign o_wb_we      = w_ok_load;
    assign o_wb_rd      = w_ok_load ? r_rd : 5'd0;
    assign o_wb_data    = w_ok_load ? r_rdata : 32'd0;
    assign o_exc_valid  = w_done && r_exc;
    assign o_exc_cause  = (w_done && r_exc) ? r_cause : 4'd0;
    assign o_exc_addr   = (w_done && r_exc) ? r_addr : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit. A driver issues directed
//               and random accesses and queues the reference result; a memory
//               responder acknowledges after a chosen delay; a monitor pops and
//               compares whenever o_done_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_fn;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        done_valid, wb_we, exc_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_addr;
    logic [3:0]  exc_cause;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .TIMEOUT_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_fn(req_fn),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_rd(req_rd),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wstrb(mem_wstrb), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
        .o_done_valid(done_valid), .o_wb_we(wb_we), .o_wb_rd(wb_rd),
        .o_wb_data(wb_data), .o_exc_valid(exc_valid), .o_exc_cause(exc_cause),
        .o_exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        exc_valid;
        logic [3:0]  cause;
        logic [31:0] exc_addr;
        int          done_cyc;
        int          req_cycles;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          reqcnt = 0;
    logic [31:0] cur_word = 32'd0;
    int          cur_delay = 0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_maddr = 32'd0;
    logic [31:0] exp_wdata = 32'd0;
    logic [3:0]  exp_wstrb = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: result of one access from the architectural rules.
    function automatic exp_t model(input logic [3:0] fn, input logic [31:0] a,
                                   input logic [4:0] rd, input logic [31:0] word,
                                   input int delay, input int t0);
        exp_t        e;
        int          sz;
        int          lane;
        logic [31:0] v;
        sz   = int'(fn[1:0]);
        lane = int'(a % 4);
        e.wb_we = 1'b0; e.wb_rd = 5'd0; e.wb_data = 32'd0;
        e.exc_valid = 1'b0; e.cause = 4'd0; e.exc_addr = 32'd0;
        if (sz == 3) begin
            e.exc_valid = 1'b1; e.cause = 4'd2; e.exc_addr = a;
            e.done_cyc = t0; e.req_cycles = 0;
        end else if ((sz == 1 && (a % 2) != 0) || (sz == 2 && lane != 0)) begin
            e.exc_valid = 1'b1; e.cause = fn[3] ? 4'd6 : 4'd4; e.exc_addr = a;
            e.done_cyc = t0; e.req_cycles = 0;
        end else if (delay >= TO) begin
            e.exc_valid = 1'b1; e.cause = fn[3] ? 4'd7 : 4'd5; e.exc_addr = a;
            e.done_cyc = t0 + TO; e.req_cycles = TO;
        end else begin
            e.done_cyc = t0 + 1 + delay; e.req_cycles = delay + 1;
            if (!fn[3]) begin
                if (sz == 0) begin
                    v = (word >> (8 * lane)) & 32'hFF;
                    if (!fn[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
                end else if (sz == 1) begin
                    v = (word >> (8 * lane)) & 32'hFFFF;
                    if (!fn[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
                end else begin
                    v = word;
                end
                e.wb_we = 1'b1; e.wb_rd = rd; e.wb_data = v;
            end
        end
        return e;
    endfunction

    // Driver: waits for ready, queues the expected result, presents one request.
    task automatic issue(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic [31:0] word, input int delay);
        int n = 0;
        int lane;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL ready_wait: got ready=0 want ready=1 within 200 cycles");
            return;
        end
        sbq.push_back(model(fn, a, rd, word, delay, cyc + 1));
        lane      = int'(a % 4);
        cur_word  = word;
        cur_delay = delay;
        exp_we    = fn[3];
        exp_maddr = a & 32'hFFFF_FFFC;
        if (!fn[3])            exp_wstrb = 4'h0;
        else if (fn[1:0] == 0) exp_wstrb = 4'(1 << lane);
        else if (fn[1:0] == 1) exp_wstrb = 4'(3 << lane);
        else                   exp_wstrb = 4'hF;
        if (fn[1:0] == 0)      exp_wdata = (d & 32'hFF) * 32'h0101_0101;
        else if (fn[1:0] == 1) exp_wdata = (d & 32'hFFFF) * 32'h0001_0001;
        else                   exp_wdata = d;
        req_valid = 1'b1; req_fn = fn; req_addr = a; req_wdata = d; req_rd = rd;
        @(negedge clk);
        // Scramble request fields after the accept edge; the DUT must have latched them.
        req_valid = 1'b0; req_fn = 4'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_rd = 5'($urandom);
    endtask

    // Memory responder: acks after cur_delay wait cycles, random ack noise when idle.
    initial begin : p_mem
        int wcnt;
        wcnt = 0; mem_ack = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                reqcnt++;
                check("mem_we", 32'(mem_we), 32'(exp_we));
                check("mem_addr", mem_addr, exp_maddr);
                check("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
                mem_ack   = (wcnt == cur_delay);
                mem_rdata = mem_ack ? cur_word : $urandom;
                wcnt++;
            end else begin
                wcnt      = 0;
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on each completion.
    initial begin : p_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (done_valid) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done_valid=1 want no completion (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("mem_req_cycles", 32'(reqcnt), 32'(e.req_cycles));
                    check("wb_we", 32'(wb_we), 32'(e.wb_we));
                    check("wb_rd", 32'(wb_rd), 32'(e.wb_rd));
                    check("wb_data", wb_data, e.wb_data);
                    check("exc_valid", 32'(exc_valid), 32'(e.exc_valid));
                    check("exc_cause", 32'(exc_cause), 32'(e.cause));
                    check("exc_addr", exc_addr, e.exc_addr);
                    check("ready_in_done", 32'(req_ready), 32'd0);
                    reqcnt = 0;
                end
            end else begin
                check("quiet_outputs",
                      wb_data | exc_addr | {22'd0, wb_we, exc_valid, exc_cause, wb_rd}, 32'd0);
            end
        end
    end

    initial begin : p_main
        int n;
        logic [3:0]  fn;
        logic [31:0] a;
        int          dly;
        rst = 1'b1; req_valid = 1'b0; req_fn = 4'd0; req_addr = 32'd0;
        req_wdata = 32'd0; req_rd = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_mem_req", {mem_req, mem_we, mem_wstrb}, 32'd0);
        check("rst_mem_addr", mem_addr | mem_wdata, 32'd0);
        check("rst_done", {done_valid, wb_we, exc_valid, exc_cause, wb_rd}, 32'd0);
        check("rst_data", wb_data | exc_addr, 32'd0);
        #2 rst = 1'b0;

        // Directed cases
        issue(4'b0000, 32'h0000_1003, 32'h0, 5'd5, 32'h80FF_1234, 0);   // LB sign-extend
        issue(4'b0101, 32'h0000_2002, 32'h0, 5'd6, 32'hBEEF_0000, 3);   // LHU, 3 waits
        issue(4'b1000, 32'h0000_0011, 32'h1234_56AB, 5'd7, 32'h0, 1);   // SB lane 1
        issue(4'b0010, 32'h0000_0002, 32'h0, 5'd8, 32'h0, 0);           // LW misaligned
        issue(4'b1001, 32'h0000_0001, 32'h0, 5'd9, 32'h0, 0);           // SH misaligned
        issue(4'b0011, 32'h0000_0040, 32'h0, 5'd9, 32'h0, 0);           // illegal size
        issue(4'b1010, 32'h0000_0100, 32'hCAFE_F00D, 5'd1, 32'h0, 1000); // SW timeout
        issue(4'b1010, 32'h0000_0104, 32'hCAFE_F00D, 5'd1, 32'h0, TO - 1); // ack on last cycle
        issue(4'b0010, 32'h0000_0200, 32'h0, 5'd3, 32'h0, TO);          // LW fault
        issue(4'b0100, 32'h0000_0302, 32'h0, 5'd4, 32'h00F1_0000, 2);   // LBU lane 2

        // Reset during BUSY
        issue(4'b0010, 32'h0000_0400, 32'h0, 5'd2, 32'h0, 1000);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        sbq.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        reqcnt = 0;
        issue(4'b0010, 32'h0000_0408, 32'h0, 5'd10, 32'h1357_9BDF, 1);  // LW after reset

        // Random accesses
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            fn  = 4'($urandom);
            a   = $urandom;
            dly = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, TO + 1));
            issue(fn, a, $urandom, 5'($urandom), $urandom, dly);
        end

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
